// File: rtl/lse_mult_pipe.sv
// lse_mult_pipe
//   Pipelined multi-lane log-space multiplier. A log-space product is the
//   two's-complement sum of the operand logs, with NEG_INF = 1<<(WIDTH-1)
//   standing for log(0). Each lane adds its operands, flags signed positive
//   (ovf) or negative (udf) overflow, and either wraps or saturates
//   depending on the per-transfer mode. Results leave the block PIPE_STAGES
//   cycles after they are accepted, and two saturating counters tally the
//   flag events that are delivered downstream.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_valid, o_ready    input handshake
//   i_operand_a/_b      LANES packed operands, lane k in [k*WIDTH +: WIDTH]
//   i_pe_mode           00 wrap, anything else saturate; travels with data
//   o_valid, i_ready    output handshake
//   o_result            LANES packed per-lane results
//   o_ovf, o_udf        per-lane overflow / underflow flags
//   i_clr_stats         synchronous clear of both counters (wins over events)
//   o_ovf_cnt/o_udf_cnt saturating counts of delivered flag events
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The whole pipeline advances together whenever the output slot
// is empty or being drained (o_ready = ~o_valid | i_ready), so bubbles are
// not collapsed and o_result/o_ovf/o_udf stay frozen while o_valid is held
// against a low i_ready.

module lse_mult_pipe #(
    parameter int WIDTH       = 24,
    parameter int LANES       = 2,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES*WIDTH-1:0] i_operand_a,
    input  logic [LANES*WIDTH-1:0] i_operand_b,
    input  logic [1:0]             i_pe_mode,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LANES*WIDTH-1:0] o_result,
    output logic [LANES-1:0]       o_ovf,
    output logic [LANES-1:0]       o_udf,
    input  logic                   i_clr_stats,
    output logic [CNT_WIDTH-1:0]   o_ovf_cnt,
    output logic [CNT_WIDTH-1:0]   o_udf_cnt
);

    localparam logic [WIDTH-1:0]     NI      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     MAX     = ~NI;
    localparam int                   PW      = $clog2(LANES + 1);
    localparam int                   SW      = CNT_WIDTH + PW;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Stage-0 arithmetic
    // ------------------------------------------------------------------
    logic                   w_sat;
    logic [LANES*WIDTH-1:0] w_res_all;
    logic [LANES-1:0]       w_ovf_all;
    logic [LANES-1:0]       w_udf_all;

    assign w_sat = i_pe_mode[1] | i_pe_mode[0];

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [WIDTH-1:0] w_a;
            logic [WIDTH-1:0] w_b;
            logic [WIDTH:0]   w_sum;
            logic             w_ninf;
            logic             w_pos;
            logic             w_neg;
            logic [WIDTH-1:0] w_res;

            assign w_a    = i_operand_a[k*WIDTH +: WIDTH];
            assign w_b    = i_operand_b[k*WIDTH +: WIDTH];
            assign w_sum  = {w_a[WIDTH-1], w_a} + {w_b[WIDTH-1], w_b};
            assign w_ninf = (w_a == NI) | (w_b == NI);
            // Top two sum bits disagree exactly when the sum left the
            // WIDTH-bit signed range; a sum of exactly NI keeps them equal.
            assign w_pos  = ~w_ninf & ~w_sum[WIDTH] &  w_sum[WIDTH-1];
            assign w_neg  = ~w_ninf &  w_sum[WIDTH] & ~w_sum[WIDTH-1];

            always_comb begin
                w_res = w_sum[WIDTH-1:0];
                if (w_ninf) begin
                    w_res = NI;
                end else if (w_sat && w_pos) begin
                    w_res = MAX;
                end else if (w_sat && w_neg) begin
                    w_res = NI;
                end
            end

            assign w_res_all[k*WIDTH +: WIDTH] = w_res;
            assign w_ovf_all[k]                = w_pos;
            assign w_udf_all[k]                = w_neg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                                      w_en;
    logic [PIPE_STAGES-1:0]                    r_vld;
    logic [PIPE_STAGES-1:0][LANES*WIDTH-1:0]   r_res;
    logic [PIPE_STAGES-1:0][LANES-1:0]         r_ovf;
    logic [PIPE_STAGES-1:0][LANES-1:0]         r_udf;

    assign w_en    = ~r_vld[PIPE_STAGES-1] | i_ready;
    assign o_ready = w_en;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= '0;
            r_res <= '0;
            r_ovf <= '0;
            r_udf <= '0;
        end else if (w_en) begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_res[0] <= w_res_all;
                r_ovf[0] <= w_ovf_all;
                r_udf[0] <= w_udf_all;
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                // Payload only moves with a valid token; bubbles leave it.
                if (r_vld[s-1]) begin
                    r_res[s] <= r_res[s-1];
                    r_ovf[s] <= r_ovf[s-1];
                    r_udf[s] <= r_udf[s-1];
                end
            end
        end
    end

    assign o_valid  = r_vld[PIPE_STAGES-1];
    assign o_result = r_res[PIPE_STAGES-1];
    assign o_ovf    = r_ovf[PIPE_STAGES-1];
    assign o_udf    = r_udf[PIPE_STAGES-1];

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] popcnt(input logic [LANES-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    logic [CNT_WIDTH-1:0] r_ovf_cnt;
    logic [CNT_WIDTH-1:0] r_udf_cnt;
    logic [SW-1:0]        w_ovf_sum;
    logic [SW-1:0]        w_udf_sum;
    logic                 w_out_xfer;

    assign w_out_xfer = r_vld[PIPE_STAGES-1] & i_ready;
    // Extra PW headroom bits expose any carry past the counter width.
    assign w_ovf_sum  = {{PW{1'b0}}, r_ovf_cnt} + SW'(popcnt(o_ovf));
    assign w_udf_sum  = {{PW{1'b0}}, r_udf_cnt} + SW'(popcnt(o_udf));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf_cnt <= '0;
            r_udf_cnt <= '0;
        end else if (i_clr_stats) begin
            r_ovf_cnt <= '0;
            r_udf_cnt <= '0;
        end else if (w_out_xfer) begin
            r_ovf_cnt <= (|w_ovf_sum[SW-1:CNT_WIDTH]) ? CNT_MAX : w_ovf_sum[CNT_WIDTH-1:0];
            r_udf_cnt <= (|w_udf_sum[SW-1:CNT_WIDTH]) ? CNT_MAX : w_udf_sum[CNT_WIDTH-1:0];
        end
    end

    assign o_ovf_cnt = r_ovf_cnt;
    assign o_udf_cnt = r_udf_cnt;

endmodule

// File: tb/tb_lse_mult_pipe.sv
// Bench for lse_mult_pipe with WIDTH=24, LANES=2, PIPE_STAGES=2, CNT_WIDTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Expected output vectors are queued at acceptance and popped
// by the output monitor on every output handshake.

module tb_lse_mult_pipe;

    localparam int W  = 24;
    localparam int L  = 2;
    localparam int PS = 2;
    localparam int CW = 4;
    localparam int EW = 2*L + L*W;   // {udf, ovf, result}

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic [L*W-1:0]   i_operand_a;
    logic [L*W-1:0]   i_operand_b;
    logic [1:0]       i_pe_mode;
    logic             o_valid;
    logic             i_ready;
    logic [L*W-1:0]   o_result;
    logic [L-1:0]     o_ovf;
    logic [L-1:0]     o_udf;
    logic             i_clr_stats;
    logic [CW-1:0]    o_ovf_cnt;
    logic [CW-1:0]    o_udf_cnt;

    lse_mult_pipe #(.WIDTH(W), .LANES(L), .PIPE_STAGES(PS), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_pe_mode(i_pe_mode),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_ovf(o_ovf), .o_udf(o_udf), .i_clr_stats(i_clr_stats),
        .o_ovf_cnt(o_ovf_cnt), .o_udf_cnt(o_udf_cnt)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    int acc_cyc  = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    // ---------------- expectation helpers ----------------
    function automatic logic [EW-1:0] mk(input logic [W-1:0] r1, input logic [W-1:0] r0,
                                         input logic [1:0] ovf, input logic [1:0] udf);
        return {udf, ovf, r1, r0};
    endfunction

    // Independent integer reference: {udf, ovf, result} for one lane.
    function automatic logic [W+1:0] lane_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sat);
        int          ia, ib, s;
        logic [31:0] su;
        logic        ov, ud;
        logic [W-1:0] r;
        ia = $signed(a);
        ib = $signed(b);
        s  = ia + ib;
        su = s;
        if (a == 24'h800000 || b == 24'h800000) begin
            return {1'b0, 1'b0, 24'h800000};
        end
        ov = (s > 8388607);
        ud = (s < -8388608);
        r  = su[W-1:0];
        if (sat && ov) r = 24'h7FFFFF;
        if (sat && ud) r = 24'h800000;
        return {ud, ov, r};
    endfunction

    function automatic logic [EW-1:0] model2(input logic [W-1:0] a1, input logic [W-1:0] b1,
                                             input logic [W-1:0] a0, input logic [W-1:0] b0,
                                             input logic [1:0] m);
        logic [W+1:0] l1, l0;
        l1 = lane_model(a1, b1, |m);
        l0 = lane_model(a0, b0, |m);
        return {l1[W+1], l0[W+1], l1[W], l0[W], l1[W-1:0], l0[W-1:0]};
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            n_checks++;
            n_out++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected: got %h, required no output", {o_udf, o_ovf, o_result});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({o_udf, o_ovf, o_result} !== mon_exp)
                    $display("FAIL out_vector: got %h, required %h", {o_udf, o_ovf, o_result}, mon_exp);
                else
                    n_pass++;
            end
        end
    end

    // ---------------- driver tasks (start/end at posedge+1) ----------------
    task automatic send(input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [1:0] m, input logic [EW-1:0] e);
        bit acc;
        acc = 0;
        i_valid     = 1'b1;
        i_operand_a = {a1, a0};
        i_operand_b = {b1, b0};
        i_pe_mode   = m;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            if (o_ready) begin
                acc     = 1;
                acc_cyc = cyc;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL send_timeout: got no accept, required accept within 100 cycles");
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        i_clr_stats = 1'b1;
        @(posedge clk);
        #1;
        i_clr_stats = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_valid, o_result, o_ovf, o_udf, o_ovf_cnt, o_udf_cnt} !== '0)
            $display("FAIL reset_outputs: got %h, required 0", {o_valid, o_result, o_ovf, o_udf, o_ovf_cnt, o_udf_cnt});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", o_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        // Build up a nonzero count, then reset with two vectors in flight.
        send(24'h7FFFFF, 24'h000001, 24'h7FFFFF, 24'h000001, 2'b00,
             mk(24'h800000, 24'h800000, 2'b11, 2'b00));
        wait_drain();
        n_checks++;
        if (o_ovf_cnt !== 4'd2) $display("FAIL pre_reset_cnt: got %0d, required 2", o_ovf_cnt);
        else n_pass++;
        send(24'h000001, 24'h000002, 24'h000003, 24'h000004, 2'b00, '0);
        send(24'h7FFFFF, 24'h000010, 24'h800001, 24'hFFFF00, 2'b00, '0);
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_checks++;
        if ({o_valid, o_ovf_cnt, o_udf_cnt} !== '0)
            $display("FAIL reset_midstream: got valid=%b ovf_cnt=%0d udf_cnt=%0d, required all 0",
                     o_valid, o_ovf_cnt, o_udf_cnt);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            n_checks++;
            if (o_valid !== 1'b0) $display("FAIL reset_discard: got o_valid=%b, required 0", o_valid);
            else n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        clear_stats();
        send(24'hFFFFFF, 24'h000001, 24'h7FFFFF, 24'h000001, 2'b00,
             mk(24'h000000, 24'h800000, 2'b01, 2'b00));
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_valid) break;
        end
        n_checks++;
        if (o_valid !== 1'b1 || (cyc - acc_cyc) != PS)
            $display("FAIL wrap_latency: got valid=%b latency=%0d, required valid=1 latency=%0d",
                     o_valid, cyc - acc_cyc, PS);
        else n_pass++;
        n_checks++;
        if ({o_result, o_ovf, o_udf} !== {48'h000000_800000, 2'b01, 2'b00})
            $display("FAIL wrap_value: got %h, required %h", {o_result, o_ovf, o_udf}, {48'h000000_800000, 2'b01, 2'b00});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (o_ovf_cnt !== 4'd1 || o_udf_cnt !== 4'd0)
            $display("FAIL wrap_cnt: got ovf=%0d udf=%0d, required 1 0", o_ovf_cnt, o_udf_cnt);
        else n_pass++;
    endtask

    task automatic test_saturate();
        clear_stats();
        send(24'h800001, 24'hFFFFFE, 24'h7FFFFF, 24'h000001, 2'b01,
             mk(24'h800000, 24'h7FFFFF, 2'b01, 2'b10));
        send(24'h800001, 24'hFFFFFE, 24'h7FFFFF, 24'h000001, 2'b00,
             mk(24'h7FFFFF, 24'h800000, 2'b01, 2'b10));
        send(24'h800001, 24'hFFFFFE, 24'h7FFFFF, 24'h000001, 2'b10,
             mk(24'h800000, 24'h7FFFFF, 2'b01, 2'b10));
        send(24'h800001, 24'hFFFFFE, 24'h7FFFFF, 24'h000001, 2'b11,
             mk(24'h800000, 24'h7FFFFF, 2'b01, 2'b10));
        wait_drain();
        n_checks++;
        if (o_ovf_cnt !== 4'd4 || o_udf_cnt !== 4'd4)
            $display("FAIL sat_cnt: got ovf=%0d udf=%0d, required 4 4", o_ovf_cnt, o_udf_cnt);
        else n_pass++;
    endtask

    task automatic test_neg_inf();
        clear_stats();
        for (int m = 0; m < 2; m++) begin
            send(24'h123456, 24'h800000, 24'h800000, 24'h123456, 2'(m),
                 mk(24'h800000, 24'h800000, 2'b00, 2'b00));
            send(24'hC00000, 24'hC00000, 24'h100000, 24'h200000, 2'(m),
                 mk(24'h800000, 24'h300000, 2'b00, 2'b00));
            send(24'h800000, 24'h800000, 24'h7FFFFF, 24'h800000, 2'(m),
                 mk(24'h800000, 24'h800000, 2'b00, 2'b00));
        end
        wait_drain();
        n_checks++;
        if (o_ovf_cnt !== 4'd0 || o_udf_cnt !== 4'd0)
            $display("FAIL neginf_cnt: got ovf=%0d udf=%0d, required 0 0", o_ovf_cnt, o_udf_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int  out0;
        int  stalls;
        logic [EW:0] prev;
        bit  prev_stall;
        out0       = n_out;
        stalls     = 0;
        prev_stall = 0;
        prev       = '0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(24'(i*3 + 1), 24'h000100, 24'(i*16), 24'h000005, 2'b00,
                         model2(24'(i*3 + 1), 24'h000100, 24'(i*16), 24'h000005, 2'b00));
                end
            end
            begin
                for (int n = 0; n < 12; n++) begin
                    i_ready = !(n >= 2 && n <= 4);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                for (int n = 0; n < 12; n++) begin
                    @(negedge clk);
                    if (prev_stall) begin
                        n_checks++;
                        if ({o_valid, o_udf, o_ovf, o_result} !== prev)
                            $display("FAIL stall_hold: got %h, required %h", {o_valid, o_udf, o_ovf, o_result}, prev);
                        else n_pass++;
                    end
                    if (o_valid && !i_ready) begin
                        stalls++;
                        n_checks++;
                        if (o_ready !== 1'b0) $display("FAIL stall_ready: got %b, required 0", o_ready);
                        else n_pass++;
                    end
                    prev_stall = o_valid && !i_ready;
                    prev       = {o_valid, o_udf, o_ovf, o_result};
                end
            end
        join
        i_ready = 1'b1;
        wait_drain();
        n_checks++;
        if (stalls != 3) $display("FAIL stall_cycles: got %0d, required 3", stalls);
        else n_pass++;
        n_checks++;
        if (n_out - out0 != 4) $display("FAIL b2b_count: got %0d, required 4", n_out - out0);
        else n_pass++;
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: return 24'h800000;
            1: return 24'h7FFFFF;
            2: return 24'h800001;
            3: return 24'h000001;
            4: return 24'hFFFFFF;
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic test_random();
        bit done;
        done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [W-1:0] a1, b1, a0, b0;
                    logic [1:0]   m;
                    a1 = rnd_op(); b1 = rnd_op(); a0 = rnd_op(); b0 = rnd_op();
                    m  = 2'($urandom_range(0, 3));
                    send(a1, b1, a0, b0, m, model2(a1, b1, a0, b0, m));
                end
                done = 1;
            end
            begin
                for (int n = 0; n < 3000 && !done; n++) begin
                    i_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        i_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_counters();
        clear_stats();
        for (int i = 0; i < 10; i++)
            send(24'h7FFFFF, 24'h000001, 24'h7FFFFF, 24'h000001, 2'b00,
                 mk(24'h800000, 24'h800000, 2'b11, 2'b00));
        for (int i = 0; i < 8; i++)
            send(24'h800001, 24'hFFFFFE, 24'h800001, 24'hFFFFFE, 2'b01,
                 mk(24'h800000, 24'h800000, 2'b00, 2'b11));
        wait_drain();
        n_checks++;
        if (o_ovf_cnt !== 4'hF || o_udf_cnt !== 4'hF)
            $display("FAIL cnt_saturate: got ovf=%h udf=%h, required F F", o_ovf_cnt, o_udf_cnt);
        else n_pass++;
        // Clear in the very cycle of an ovf event: clear must win.
        send(24'h000001, 24'h000001, 24'h7FFFFF, 24'h000001, 2'b00,
             mk(24'h000002, 24'h800000, 2'b01, 2'b00));
        @(posedge clk);
        #1;
        i_clr_stats = 1'b1;
        n_checks++;
        if (o_valid !== 1'b1 || o_ovf !== 2'b01)
            $display("FAIL clr_setup: got valid=%b ovf=%b, required 1 01", o_valid, o_ovf);
        else n_pass++;
        @(posedge clk);
        #1;
        i_clr_stats = 1'b0;
        n_checks++;
        if (o_ovf_cnt !== 4'd0 || o_udf_cnt !== 4'd0)
            $display("FAIL clr_wins: got ovf=%0d udf=%0d, required 0 0", o_ovf_cnt, o_udf_cnt);
        else n_pass++;
        send(24'h7FFFFF, 24'h000001, 24'h7FFFFF, 24'h000001, 2'b00,
             mk(24'h800000, 24'h800000, 2'b11, 2'b00));
        wait_drain();
        n_checks++;
        if (o_ovf_cnt !== 4'd2) $display("FAIL cnt_two_lanes: got %0d, required 2", o_ovf_cnt);
        else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_ready     = 1'b1;
        i_operand_a = '0;
        i_operand_b = '0;
        i_pe_mode   = 2'b00;
        i_clr_stats = 1'b0;
        test_reset();
        test_wrap();
        test_saturate();
        test_neg_inf();
        test_back_to_back();
        test_random();
        test_counters();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lse_mult_pipe.md
Name: lse_mult_pipe

Overview:
- Pipelined, multi-lane successor of the combinational log-space multiplier.
- Multiplication in log space is two's-complement addition, log(a*b) = log(a) + log(b), with NEG_INF = 1<<(WIDTH-1) representing log(0).
- Adds a valid/ready handshake, configurable pipeline depth, LANES independent lanes, a selectable wrap/saturate mode, per-lane overflow/underflow flags and saturating event counters.
- Sits between the PE operand fetch and the LSE accumulate stage.

Parameters:
WIDTH, 24, lane word width in bits (two's-complement log value).
LANES, 2, number of independent lanes packed per transfer.
PIPE_STAGES, 2, accepted-input-to-output latency in cycles; legal range 1..8.
CNT_WIDTH, 16, width of each saturating event counter.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_valid  in  1  input transfer valid.
o_ready  out  1  block can accept an input this cycle.
i_operand_a  in  LANES*WIDTH  lane k in bits [k*WIDTH +: WIDTH].
i_operand_b  in  LANES*WIDTH  same packing as i_operand_a.
i_pe_mode  in  2  00 = wrap; 01 = saturate; 1x = saturate. Sampled with the data.
o_valid  out  1  output transfer valid.
i_ready  in  1  downstream accepts output.
o_result  out  LANES*WIDTH  per-lane sum.
o_ovf  out  LANES  per-lane signed positive overflow, aligned with o_result.
o_udf  out  LANES  per-lane signed negative overflow, aligned with o_result.
i_clr_stats  in  1  synchronous clear of both counters.
o_ovf_cnt  out  CNT_WIDTH  saturating count of lane ovf events.
o_udf_cnt  out  CNT_WIDTH  saturating count of lane udf events.

Behaviour:
- Reset (asynchronous, i_rst=1): all stage valid bits, o_valid, o_result, o_ovf, o_udf, o_ovf_cnt and o_udf_cnt go to 0. o_ready=1 once reset is released. Reset mid-operation discards all in-flight data.
- Pipeline enable: en = ~o_valid | i_ready; o_ready = en. No bubble collapsing.
  - When en=1, every stage shifts one position forward and stage 0 captures i_valid together with the data.
  - When en=0, all stages hold.
- Input handshake: accept = i_valid & o_ready. Output handshake: o_valid & i_ready.
- Latency: a vector accepted at cycle t appears on o_valid at t+PIPE_STAGES, provided no stall occurs. Each stall cycle adds one cycle. Order is always preserved.
- Data are registered only in valid stages; a bubble carries a valid bit of 0.
- Per-lane arithmetic, performed in stage 0:
  - s = a + b as a (WIDTH+1)-bit signed sum. NI = 1<<(WIDTH-1); MAX = NI-1.
  - If a==NI or b==NI: result = NI, ovf = 0, udf = 0.
  - Otherwise ovf = (s > MAX) and udf = (s < -NI).
  - Wrap mode: result = s[WIDTH-1:0].
  - Saturate mode: result = MAX if ovf, NI if udf, otherwise s[WIDTH-1:0].
  - A non-overflowing sum that equals exactly NI is a legal result, not an underflow.
  - Flags are reported in both modes.
- Lanes are fully independent. Mode is shared by all lanes of a transfer.
- Counters:
  - On each output handshake, o_ovf_cnt increases by popcount(o_ovf) and o_udf_cnt by popcount(o_udf).
  - Each counter saturates at 2^CNT_WIDTH-1 and never wraps.
  - i_clr_stats=1 sets both counters to 0 on the next edge. When a clear coincides with an event, the clear wins and that cycle's events are dropped.
- While o_valid=1 and i_ready=0, o_result, o_ovf and o_udf are held stable.

Test Plan:
1. Reset behaviour (WIDTH=24, LANES=2, PIPE_STAGES=2): assert i_rst mid-stream with 2 vectors in flight -> o_valid=0, both counters=0 immediately; after release the in-flight vectors never appear.
2. Wrap mode, mode 00, continuous i_ready=1:
   - lane0 7FFFFF+000001 -> 800000, ovf=1.
   - lane1 FFFFFF+000001 -> 000000, no flags.
   - Output appears exactly 2 cycles after accept; o_ovf_cnt=1.
3. Saturate mode, mode 01:
   - lane0 7FFFFF+000001 -> 7FFFFF, ovf=1.
   - lane1 800001+FFFFFE -> 800000, udf=1 (the same lane in mode 00 -> 7FFFFF, udf=1).
4. NEG_INF absorption, both modes: 800000+123456 and 123456+800000 -> 800000, no flags; 100000+200000 -> 300000.
5. Backpressure: offer 4 back-to-back vectors with i_ready low for cycles 2-4 -> o_ready low while o_valid & ~i_ready, held output stable, all 4 results delivered in order with none lost or duplicated.
6. Counters with CNT_WIDTH=4:
   - Drive 20 ovf events -> o_ovf_cnt sticks at F.
   - Assert i_clr_stats in the same cycle as an event -> counter = 0.
